// File: rtl/ibex_mem_responder_pkg.sv
// Shared types and integrity helper for the memory responder.
package ibex_mem_responder_pkg;

    localparam int unsigned RspDataW = 32;
    localparam int unsigned IntgW    = 7;

    // One queued response: read data (zero for writes/errors) and error flag
    typedef struct packed {
        logic [RspDataW-1:0] rdata;
        logic                error;
    } rsp_entry_t;

    // Inverted Hsiao SECDED(39,32) check bits; the inversion keeps all-zero words non-codewords
    function automatic logic [IntgW-1:0] gen_intg(input logic [31:0] data);
        logic [IntgW-1:0] chk;
        chk[0] = ^(data & 32'h2606BD25);
        chk[1] = ^(data & 32'hDEBA8050);
        chk[2] = ^(data & 32'h413D89AA);
        chk[3] = ^(data & 32'h31234ED1);
        chk[4] = ^(data & 32'hC2C1323B);
        chk[5] = ^(data & 32'h2DCC624C);
        chk[6] = ^(data & 32'h98505586);
        return chk ^ 7'h2A;
    endfunction

endpackage

// File: rtl/ibex_mem_responder_fifo.sv
// In-order response queue with occupancy count.
module ibex_mem_responder_fifo
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = rsp_entry_t,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           store_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = store_q[rptr_q];
    assign count_o = count_q;

    // Next pointer/count; simultaneous push and pop leave count unchanged
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset drops all pending entries
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, no reset needed since count gates visibility
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            store_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-backed responder for the Ibex request/grant/rvalid bus with programmable delays.
module ibex_mem_responder
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned INTG_WIDTH      = 7,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    request,
    output logic                    grant,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [INTG_WIDTH-1:0]   wintg,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [INTG_WIDTH-1:0]   rintg,
    output logic                    error,
    input  logic [3:0]              gnt_delay,
    input  logic [3:0]              rsp_delay
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [3:0]            head_cnt_q, head_cnt_d;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      word_idx;
    logic                  decode_err, intg_err, acc_err;
    logic                  mem_we, rsp_fire;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [CNT_W-1:0]      q_count;
    logic                  q_empty, q_full;
    rsp_entry_t            push_entry, head_entry;

    // Address decode and write-data integrity check
    assign offset     = addr - BASE;
    assign word_idx   = offset[IDX_W+1:2];
    assign decode_err = (addr < BASE) || (offset >= SPAN) || (addr[1:0] != 2'b00);
    assign intg_err   = we && (wintg != INTG_WIDTH'(gen_intg(32'(wdata))));
    assign acc_err    = decode_err || intg_err;

    // Grant and response-fire; a full queue blocks grant even when popping.
    // Firing on >= keeps the head from stalling if rsp_delay is lowered mid-wait.
    assign grant    = !reset && request && (wait_cnt_q >= gnt_delay) && !q_full;
    assign rsp_fire = !reset && !q_empty && (head_cnt_q >= rsp_delay);
    assign mem_we   = grant && we && !acc_err;

    // Response entry built at accept: read data only for good reads
    always_comb begin
        push_entry.rdata = '0;
        push_entry.error = acc_err;
        if (!acc_err && !we) begin
            push_entry.rdata = RspDataW'(mem_q[word_idx]);
        end
    end

    // Byte-enable merge of write data into the current word
    always_comb begin
        wr_word = mem_q[word_idx];
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                wr_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Backing store, retained across reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // Next values of the grant wait counter and head-age counter
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        head_cnt_d = head_cnt_q;
        if (!request || grant) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if (q_empty || rsp_fire) begin
            head_cnt_d = 4'd0;
        end else if (head_cnt_q != 4'hF) begin
            head_cnt_d = head_cnt_q + 4'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
            head_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            head_cnt_q <= head_cnt_d;
        end
    end

    ibex_mem_responder_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .entry_t (rsp_entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (grant),
        .push_data_i (push_entry),
        .pop_i       (rsp_fire),
        .head_o      (head_entry),
        .count_o     (q_count),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Response outputs, zeroed whenever no response is presented
    always_comb begin
        rvalid = rsp_fire;
        rdata  = '0;
        rintg  = '0;
        error  = 1'b0;
        if (rsp_fire) begin
            rdata = DATA_WIDTH'(head_entry.rdata);
            rintg = INTG_WIDTH'(gen_intg(head_entry.rdata));
            error = head_entry.error;
        end
    end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed self-checking bench for ibex_mem_responder.
module tb_ibex_mem_responder;

    logic        clk = 1'b0;
    logic        reset, request, grant, we, rvalid, error;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be, gnt_delay, rsp_delay;
    logic [6:0]  wintg, rintg;

    int n_vec = 0;
    int n_err = 0;

    int exp_acc [6] = '{0, 1, 2, 3, 7, 13};
    int exp_rsp [6] = '{6, 12, 18, 24, 30, 36};
    int acc_cyc [6] = '{-1, -1, -1, -1, -1, -1};
    int rsp_cyc [6] = '{-1, -1, -1, -1, -1, -1};
    logic [31:0] rsp_dat [6];

    always #5 clk = ~clk;

    ibex_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .request   (request),
        .grant     (grant),
        .addr      (addr),
        .we        (we),
        .be        (be),
        .wdata     (wdata),
        .wintg     (wintg),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rintg     (rintg),
        .error     (error),
        .gnt_delay (gnt_delay),
        .rsp_delay (rsp_delay)
    );

    // Reference check bits, computed bit by bit from the code's parity rows
    function automatic logic [6:0] ref_intg(input logic [31:0] d);
        logic [31:0] row;
        logic [6:0]  c;
        c = 7'h2A;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       row = 32'h2606BD25;
                1:       row = 32'hDEBA8050;
                2:       row = 32'h413D89AA;
                3:       row = 32'h31234ED1;
                4:       row = 32'hC2C1323B;
                5:       row = 32'h2DCC624C;
                default: row = 32'h98505586;
            endcase
            for (int k = 0; k < 32; k++) begin
                if (row[k] && d[k]) c[i] = ~c[i];
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold one request until granted; returns one cycle after the accept edge
    task automatic do_req(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [6:0] ig, output int waited);
        request = 1'b1; we = w; addr = a; be = b; wdata = d; wintg = ig;
        waited = 0;
        #1;
        while (!grant && waited < 40) begin
            cyc();
            waited++;
        end
        chk({tag, "_grant"}, grant, 1);
        cyc();
        request = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; wintg = '0;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"},  rdata,  0);
        chk({tag, "_rintg"},  rintg,  0);
        chk({tag, "_error"},  error,  0);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] d, input logic e);
        chk({tag, "_rvalid"}, rvalid, 1);
        chk({tag, "_rdata"},  rdata,  d);
        chk({tag, "_rintg"},  rintg,  ref_intg(d));
        chk({tag, "_error"},  error,  e);
    endtask

    initial begin
        int w, acc_n, rsp_n, cyc_i, n_rv;
        logic g_s;

        reset = 1'b1; request = 1'b1; we = 1'b0; addr = 32'h10; be = '0;
        wdata = '0; wintg = '0; gnt_delay = 4'd0; rsp_delay = 4'd0;
        #2;
        chk("rst_grant", grant, 0);
        chk_idle("rst");
        repeat (2) cyc();
        chk("rst2_grant", grant, 0);
        chk_idle("rst2");
        reset = 1'b0; request = 1'b0;

        // Full-word write then read back, grant in the first reset-free cycle
        do_req("wr_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ref_intg(32'hDEADBEEF), w);
        chk("wr_full_wait", w, 0);
        chk("wr_full_rintg0", rintg, 7'h2A);
        chk_rsp("wr_full", 32'h0, 1'b0);
        cyc();
        chk_idle("after_wr");
        do_req("rd_full", 1'b0, 32'h10, 4'h0, 32'h0, 7'h0, w);
        chk("rd_full_wait", w, 0);
        chk_rsp("rd_full", 32'hDEADBEEF, 1'b0);
        cyc();

        // Partial write, read issued in the very next cycle
        do_req("wr_part", 1'b1, 32'h10, 4'b0001, 32'h000000AA, ref_intg(32'h000000AA), w);
        chk_rsp("wr_part", 32'h0, 1'b0);
        do_req("rd_part", 1'b0, 32'h10, 4'hF, 32'h0, 7'h0, w);
        chk_rsp("rd_part", 32'hDEADBEAA, 1'b0);
        cyc();

        // Error responses leave memory untouched
        do_req("mis", 1'b0, 32'h2, 4'hF, 32'h0, 7'h0, w);
        chk_rsp("mis", 32'h0, 1'b1);
        cyc();
        do_req("oor", 1'b0, 32'h1000, 4'hF, 32'h0, 7'h0, w);
        chk_rsp("oor", 32'h0, 1'b1);
        cyc();
        do_req("badintg", 1'b1, 32'h10, 4'hF, 32'h12345678, ref_intg(32'h12345678) ^ 7'h01, w);
        chk_rsp("badintg", 32'h0, 1'b1);
        cyc();
        do_req("rd_keep", 1'b0, 32'h10, 4'hF, 32'h0, 7'h0, w);
        chk_rsp("rd_keep", 32'hDEADBEAA, 1'b0);
        cyc();

        // Grant delay: 4th request-high cycle, restart after a dropped request
        gnt_delay = 4'd3;
        do_req("gd", 1'b0, 32'h10, 4'h0, 32'h0, 7'h0, w);
        chk("gd_wait", w, 3);
        chk_rsp("gd", 32'hDEADBEAA, 1'b0);
        cyc();
        request = 1'b1; addr = 32'h10; we = 1'b0;
        #1;
        chk("gd_drop_c1", grant, 0);
        cyc();
        chk("gd_drop_c2", grant, 0);
        request = 1'b0;
        cyc();
        do_req("gd_re", 1'b0, 32'h10, 4'h0, 32'h0, 7'h0, w);
        chk("gd_re_wait", w, 3);
        cyc();
        gnt_delay = 4'd0;

        // Back-to-back reads against a 4-deep queue with rsp_delay=5
        for (int i = 0; i < 6; i++) begin
            do_req("pre", 1'b1, 32'h20 + 32'(4 * i), 4'hF, 32'hA5A50000 + 32'(i * 32'h111),
                   ref_intg(32'hA5A50000 + 32'(i * 32'h111)), w);
            cyc();
        end
        rsp_delay = 4'd5;
        acc_n = 0; rsp_n = 0; cyc_i = 0;
        while ((acc_n < 6 || rsp_n < 6) && cyc_i < 80) begin
            request = (acc_n < 6); we = 1'b0; addr = 32'h20 + 32'(4 * acc_n);
            #1;
            g_s = grant;
            if (g_s && acc_n < 6) acc_cyc[acc_n] = cyc_i;
            if (rvalid) begin
                if (rsp_n < 6) begin
                    rsp_cyc[rsp_n] = cyc_i;
                    rsp_dat[rsp_n] = rdata;
                end
                rsp_n++;
            end
            cyc();
            if (g_s) acc_n++;
            cyc_i++;
        end
        request = 1'b0;
        chk("q_acc_n", acc_n, 6);
        chk("q_rsp_n", rsp_n, 6);
        for (int i = 0; i < 6; i++) begin
            chk("q_acc_cyc", acc_cyc[i], exp_acc[i]);
            chk("q_rsp_cyc", rsp_cyc[i], exp_rsp[i]);
            chk("q_rsp_dat", rsp_dat[i], 32'hA5A50000 + 32'(i * 32'h111));
        end

        // Reset with three pending responses discards them
        request = 1'b1; we = 1'b0; addr = 32'h10;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("pend_grant", grant, 1);
            cyc();
        end
        reset = 1'b1;
        #1;
        chk("rstp_grant", grant, 0);
        chk_idle("rstp");
        cyc();
        reset = 1'b0; request = 1'b0;
        #1;
        n_rv = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) n_rv++;
            cyc();
        end
        chk("rstp_no_rvalid", n_rv, 0);

        // Memory retained across reset; accept on the first reset-free cycle
        rsp_delay = 4'd0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        do_req("retain", 1'b0, 32'h10, 4'h0, 32'h0, 7'h0, w);
        chk("retain_wait", w, 0);
        chk_rsp("retain", 32'hDEADBEAA, 1'b0);
        cyc();
        do_req("retain2", 1'b0, 32'h2C, 4'h0, 32'h0, 7'h0, w);
        chk_rsp("retain2", 32'hA5A50333, 1'b0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_mem_responder.md
IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; INTG_WIDTH, default 7, integrity width.
REQ-002 Parameters: MEM_WORDS, default 1024, backing-store depth in words; BASE_ADDR, default 32'h0, first mapped byte address; MAX_OUTSTANDING, default 4, response-queue depth.
REQ-003 Ports, in order:
- clk  input  1  clock; single clock domain.
- reset  input  1  reset; synchronous, active-high.
- request  input  1  initiator request.
- grant  output  1  request accepted this cycle.
- addr  input  ADDR_WIDTH  byte address.
- we  input  1  1 = write, 0 = read.
- be  input  DATA_WIDTH/8  byte enables.
- wdata  input  DATA_WIDTH  write data.
- wintg  input  INTG_WIDTH  write-data integrity bits.
- rvalid  output  1  response valid.
- rdata  output  DATA_WIDTH  read data.
- rintg  output  INTG_WIDTH  rdata integrity bits.
- error  output  1  response error; qualified by rvalid.
- gnt_delay  input  4  minimum request-high cycles before grant.
- rsp_delay  input  4  extra cycles a queue-head entry waits before rvalid.

Function
REQ-004 A transaction is accepted on a rising clk edge where request and grant are both 1.
REQ-005 grant is combinational: request AND wait_cnt >= gnt_delay AND outstanding count < MAX_OUTSTANDING.
REQ-006 wait_cnt increments on cycles with request=1 and grant=0, saturates at 15, and clears on grant or when request=0.
REQ-007 A full queue (count == MAX_OUTSTANDING) forces grant=0, even if a pop occurs in the same cycle.
REQ-008 Decode error: addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) or addr[1:0] != 0.
REQ-009 Integrity error: we=1 and wintg != gen_intg(wdata).
REQ-010 A decode or integrity error at accept causes no memory write and queues an entry with error=1, rdata=0.
REQ-011 A good write updates memory at the accept edge for each byte whose be bit is 1, and queues an entry with rdata=0, error=0.
REQ-012 A good read samples the memory word at accept, ignores be, and queues an entry with that data, error=0.
REQ-013 A read accepted one cycle after a write to the same word returns the written data.
REQ-014 Responses are returned strictly in accept order, at most one per cycle.
REQ-015 Head counter clears when an entry becomes head and increments each cycle after that; rvalid=1 when head counter == rsp_delay, and the entry pops that cycle.
REQ-016 Latency: with rsp_delay=0 and an empty queue, rvalid rises exactly one cycle after accept; each queued entry behind the head adds at least one cycle.
REQ-017 rintg = gen_intg(rdata) on every cycle rvalid=1.
REQ-018 Push and pop in the same cycle leave the count unchanged; there is no count overflow or underflow.
REQ-019 Whenever rvalid=0: rdata=0, rintg=0, error=0.

Reset
REQ-020 While reset=1: queue empties, wait_cnt and head counter are 0, grant=0, rvalid=0, rdata=0, rintg=0, error=0.
REQ-021 Reset during an outstanding transaction discards pending responses; no rvalid is issued for them.
REQ-022 Memory contents are not reset; they are retained across reset.
REQ-023 The first accept is possible on the first cycle with reset=0.

Structure
REQ-024 Shared package ibex_mem_responder_pkg holds the response-entry struct {rdata, error} and function gen_intg.
REQ-025 gen_intg returns the inverted Hsiao SECDED(39,32) check bits for a 32-bit word.
REQ-026 The response queue is a separate sub-module ibex_mem_responder_fifo, parameterised by depth and entry type, with count output.
REQ-027 Memory is a plain word array inside the top module; no other sub-modules.

Verification
REQ-028 gnt_delay=0, rsp_delay=0: write 0xDEADBEEF to 0x10 with be=4'hF and correct wintg, then read 0x10 -> grant in the request cycle, rvalid one cycle after each accept, read rdata=0xDEADBEEF with matching rintg, error=0.
REQ-029 Partial write 0x000000AA to 0x10 with be=4'b0001 over 0xDEADBEEF, then read 0x10 -> rdata=0xDEADBEAA.
REQ-030 gnt_delay=3: request held high -> grant first asserts on the 4th request-high cycle; request dropped after 2 cycles and reasserted -> count restarts from 0.
REQ-031 MAX_OUTSTANDING=4, rsp_delay=5, 6 back-to-back reads -> grant low after 4 accepts until the first pop; 6 in-order responses, each rvalid 6 cycles after its entry becomes head.
REQ-032 Error cases -> rvalid with error=1, rdata=0, memory unchanged:
- read of 0x2 (misaligned);
- read of BASE_ADDR+4*MEM_WORDS (out of range);
- write with wintg bit 0 flipped.
REQ-033 Reset asserted for one cycle with 3 responses pending -> no rvalid afterwards for those; a later read of a previously written word returns the retained data.
